sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one access per request through
// SETUP / STROBE / HOLD phases, with every pin driven from a register.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2  // strobe width in cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  output logic        memRead,
  output logic        memWrite,
  output logic        memEnable
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             we_q, we_nxt;
  logic [DW-1:0]    wdata_q, wdata_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [DW-1:0]    rdata_nxt;
  logic             ack_nxt, busy_nxt, en_nxt, rd_nxt, wr_nxt;
  logic             drive, drive_nxt;

  // Bus is driven only from registered data under a registered enable
  assign dataBus = drive ? wdata_q : {DW{1'bz}};

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      memAddr   <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      memEnable <= 1'b1;
      memRead   <= 1'b1;
      memWrite  <= 1'b1;
      drive     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      we_q      <= we_nxt;
      wdata_q   <= wdata_nxt;
      memAddr   <= addr_nxt;
      rdata     <= rdata_nxt;
      ack       <= ack_nxt;
      busy      <= busy_nxt;
      memEnable <= en_nxt;
      memRead   <= rd_nxt;
      memWrite  <= wr_nxt;
      drive     <= drive_nxt;
    end
  end

  // Next state plus the pin values for the cycle that state will occupy
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    wdata_nxt = wdata_q;
    addr_nxt  = memAddr;
    rdata_nxt = rdata;
    ack_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    en_nxt    = 1'b1;
    rd_nxt    = 1'b1;
    wr_nxt    = 1'b1;
    drive_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SETUP;
          we_nxt    = we;
          addr_nxt  = addr;
          wdata_nxt = wdata;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b0;
          drive_nxt = we;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b1;
        en_nxt    = 1'b0;
        drive_nxt = we_q;
        wr_nxt    = ~we_q;
        rd_nxt    = we_q;
      end
      STROBE: begin
        busy_nxt  = 1'b1;
        en_nxt    = 1'b0;
        drive_nxt = we_q;
        if (cnt == LAST_CNT) begin
          // Last strobe cycle: sample read data, then release strobes for HOLD
          state_nxt = HOLD;
          cnt_nxt   = '0;
          ack_nxt   = 1'b1;
          if (!we_q) rdata_nxt = dataBus;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          wr_nxt  = ~we_q;
          rd_nxt  = we_q;
        end
      end
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: WAIT_CYCLES=2 instance against a word-array
// SRAM model, plus WAIT_CYCLES=1 and 15 instances for latency.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Main instance, WAIT_CYCLES = 2
  logic        req, we;
  logic [15:0] addr, wdata, rdata, memAddr;
  logic        ack, busy, memRead, memWrite, memEnable;
  wire  [15:0] bus;
  logic [15:0] mem [0:65535];

  sram_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .memAddr(memAddr), .dataBus(bus),
    .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable)
  );

  assign bus = (!memEnable && !memRead) ? mem[memAddr] : 16'hzzzz;
  always @(posedge clk) if (!memEnable && !memWrite) mem[memAddr] <= bus;

  // WAIT_CYCLES = 1 instance
  logic        r1_req, r1_we, r1_ack, r1_busy, r1_rd, r1_wr, r1_en;
  logic [15:0] r1_addr, r1_wdata, r1_rdata, r1_maddr;
  wire  [15:0] r1_bus;
  sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(r1_req), .we(r1_we), .addr(r1_addr), .wdata(r1_wdata),
    .rdata(r1_rdata), .ack(r1_ack), .busy(r1_busy), .memAddr(r1_maddr), .dataBus(r1_bus),
    .memRead(r1_rd), .memWrite(r1_wr), .memEnable(r1_en)
  );
  assign r1_bus = (!r1_en && !r1_rd) ? 16'h4321 : 16'hzzzz;

  // WAIT_CYCLES = 15 instance
  logic        r15_req, r15_we, r15_ack, r15_busy, r15_rd, r15_wr, r15_en;
  logic [15:0] r15_addr, r15_wdata, r15_rdata, r15_maddr;
  wire  [15:0] r15_bus;
  sram_ctrl #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .req(r15_req), .we(r15_we), .addr(r15_addr), .wdata(r15_wdata),
    .rdata(r15_rdata), .ack(r15_ack), .busy(r15_busy), .memAddr(r15_maddr), .dataBus(r15_bus),
    .memRead(r15_rd), .memWrite(r15_wr), .memEnable(r15_en)
  );
  assign r15_bus = (!r15_en && !r15_rd) ? 16'hC0DE : 16'hzzzz;

  // Strobes must never overlap on any instance
  always @(negedge clk) begin
    checks++;
    if ((!memRead && !memWrite) || (!r1_rd && !r1_wr) || (!r15_rd && !r15_wr)) begin
      errors++;
      $display("FAIL strobe_overlap t=%0t rd/wr w2=%b%b w1=%b%b w15=%b%b required never both 0",
               $time, memRead, memWrite, r1_rd, r1_wr, r15_rd, r15_wr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    r15_req = 1'b0; r15_we = 1'b0; r15_addr = '0; r15_wdata = '0;
    repeat (3) tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({memEnable, memRead, memWrite} !== 3'b111) begin errors++; $display("FAIL rst_strobes got=%b exp=111", {memEnable, memRead, memWrite}); end
    checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL rst_memaddr got=%h exp=0000", memAddr); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
    checks++; if ({r1_en, r15_en, r1_busy, r15_busy} !== 4'b1100) begin errors++; $display("FAIL rst_aux got=%b exp=1100", {r1_en, r15_en, r1_busy, r15_busy}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write;
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h1234;
    tick();  // E1: SETUP
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_e1 got=%b exp=1", busy); end
    checks++; if ({memEnable, memWrite, memRead} !== 3'b011) begin errors++; $display("FAIL wr_setup_pins got=%b exp=011", {memEnable, memWrite, memRead}); end
    checks++; if (memAddr !== 16'h0010) begin errors++; $display("FAIL wr_addr_e1 got=%h exp=0010", memAddr); end
    checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL wr_bus_e1 got=%h exp=1234", bus); end
    tick();  // E2
    checks++; if ({memWrite, memRead, ack} !== 3'b010) begin errors++; $display("FAIL wr_strobe_e2 got=%b exp=010", {memWrite, memRead, ack}); end
    tick();  // E3
    checks++; if ({memWrite, memRead, ack} !== 3'b010) begin errors++; $display("FAIL wr_strobe_e3 got=%b exp=010", {memWrite, memRead, ack}); end
    checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL wr_bus_e3 got=%h exp=1234", bus); end
    tick();  // E4: HOLD
    checks++; if ({ack, busy, memEnable, memWrite} !== 4'b1101) begin errors++; $display("FAIL wr_hold_e4 got=%b exp=1101", {ack, busy, memEnable, memWrite}); end
    checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL wr_bus_e4 got=%h exp=1234", bus); end
    tick();  // E5: IDLE
    checks++; if ({ack, busy, memEnable} !== 3'b001) begin errors++; $display("FAIL wr_idle_e5 got=%b exp=001", {ack, busy, memEnable}); end
    checks++; if (bus === 16'h1234) begin errors++; $display("FAIL wr_bus_release_e5 got=%h exp=not driven", bus); end
    checks++; if (memAddr !== 16'h0010) begin errors++; $display("FAIL wr_addr_hold_e5 got=%h exp=0010", memAddr); end
    checks++; if (mem[16'h0010] !== 16'h1234) begin errors++; $display("FAIL wr_sram_content got=%h exp=1234", mem[16'h0010]); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=0000", rdata); end
  endtask

  task automatic test_read;
    req = 1'b1; we = 1'b0; addr = 16'h0010; wdata = 16'hBEEF;
    tick();  // E1
    req = 1'b0;
    checks++; if ({memEnable, memRead, memWrite} !== 3'b011) begin errors++; $display("FAIL rd_setup_pins got=%b exp=011", {memEnable, memRead, memWrite}); end
    checks++; if (bus === 16'hBEEF) begin errors++; $display("FAIL rd_bus_e1 got=%h exp=not driven", bus); end
    tick();  // E2
    checks++; if ({memRead, memWrite} !== 2'b01) begin errors++; $display("FAIL rd_strobe_e2 got=%b exp=01", {memRead, memWrite}); end
    tick();  // E3
    checks++; if ({memRead, memWrite} !== 2'b01) begin errors++; $display("FAIL rd_strobe_e3 got=%b exp=01", {memRead, memWrite}); end
    checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL rd_bus_e3 got=%h exp=1234", bus); end
    tick();  // E4
    checks++; if ({ack, memRead} !== 2'b11) begin errors++; $display("FAIL rd_ack_e4 got=%b exp=11", {ack, memRead}); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata_e4 got=%h exp=1234", rdata); end
    checks++; if (bus === 16'hBEEF) begin errors++; $display("FAIL rd_bus_e4 got=%h exp=not driven", bus); end
    tick();  // E5
    checks++; if ({ack, busy} !== 2'b00) begin errors++; $display("FAIL rd_idle_e5 got=%b exp=00", {ack, busy}); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata_e5 got=%h exp=1234", rdata); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int busy_low = 0;
    int ack_cyc [3] = '{0, 0, 0};
    req = 1'b1; we = 1'b1; addr = 16'h0000; wdata = 16'hA000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (n >= 1 && n < 3 && !busy) busy_low++;
      if (ack) begin
        if (n < 3) ack_cyc[n] = i;
        n++;
        addr  = 16'(n);
        wdata = 16'hA000 + 16'(n);
        if (n == 3) req = 1'b0;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=3", n); end
    checks++; if (ack_cyc[0] != 4 || ack_cyc[1] != 9 || ack_cyc[2] != 14) begin errors++; $display("FAIL b2b_ack_cycles got=%0d,%0d,%0d exp=4,9,14", ack_cyc[0], ack_cyc[1], ack_cyc[2]); end
    checks++; if (busy_low != 2) begin errors++; $display("FAIL b2b_busy_gap got=%0d exp=2", busy_low); end
    checks++; if (mem[0] !== 16'hA000 || mem[1] !== 16'hA001 || mem[2] !== 16'hA002) begin errors++; $display("FAIL b2b_sram got=%h,%h,%h exp=a000,a001,a002", mem[0], mem[1], mem[2]); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL b2b_rdata_hold got=%h exp=1234", rdata); end
  endtask

  task automatic test_hold_inputs;
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h0F0F;
    for (int i = 1; i <= 4; i++) begin
      tick();
      addr  = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      wdata = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      we    = (i % 2 == 0);
      req   = (i < 4) ? (i % 2 == 0) : 1'b0;
      checks++; if (memAddr !== 16'h0030 || bus !== 16'h0F0F) begin errors++; $display("FAIL hold_inputs_e%0d got addr=%h bus=%h exp addr=0030 bus=0f0f", i, memAddr, bus); end
    end
    tick();
    checks++; if (mem[16'h0030] !== 16'h0F0F) begin errors++; $display("FAIL hold_sram got=%h exp=0f0f", mem[16'h0030]); end
    checks++; if (memAddr !== 16'h0030 || busy !== 1'b0) begin errors++; $display("FAIL hold_idle got addr=%h busy=%b exp addr=0030 busy=0", memAddr, busy); end
  endtask

  task automatic test_reset_abort;
    int acks = 0;
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h5555;
    tick();  // E1
    req = 1'b0;
    tick();  // E2
    tick();  // E3: second strobe cycle
    rst = 1'b1; req = 1'b1;
    tick();
    checks++; if ({memEnable, memRead, memWrite, ack, busy} !== 5'b11100) begin errors++; $display("FAIL abort_pins got=%b exp=11100", {memEnable, memRead, memWrite, ack, busy}); end
    checks++; if (bus === 16'h5555) begin errors++; $display("FAIL abort_bus got=%h exp=not driven", bus); end
    checks++; if (memAddr !== 16'h0000 || rdata !== 16'h0000) begin errors++; $display("FAIL abort_regs got addr=%h rdata=%h exp 0000/0000", memAddr, rdata); end
    tick();
    checks++; if (busy !== 1'b0 || memEnable !== 1'b1) begin errors++; $display("FAIL abort_req_ignored got busy=%b en=%b exp 0/1", busy, memEnable); end
    rst = 1'b0; req = 1'b0;
    tick();
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      req = 1'b0;
      if (ack) acks++;
      if (i == 4) begin
        checks++; if (ack !== 1'b1 || rdata !== 16'h1234) begin errors++; $display("FAIL abort_then_read got ack=%b rdata=%h exp 1/1234", ack, rdata); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL abort_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_wait1;
    int ack_at;
    int low;
    for (int t = 0; t < 2; t++) begin
      ack_at = 0; low = 0;
      r1_req = 1'b1; r1_we = (t == 0); r1_addr = 16'h0005; r1_wdata = 16'h0077;
      for (int i = 1; i <= 25; i++) begin
        tick();
        r1_req = 1'b0;
        if ((t == 0 && !r1_wr) || (t == 1 && !r1_rd)) low++;
        if (r1_ack && ack_at == 0) ack_at = i;
      end
      checks++; if (ack_at != 3) begin errors++; $display("FAIL w1_ack_cycle t=%0d got=%0d exp=3", t, ack_at); end
      checks++; if (low != 1) begin errors++; $display("FAIL w1_strobe_len t=%0d got=%0d exp=1", t, low); end
    end
    checks++; if (r1_rdata !== 16'h4321) begin errors++; $display("FAIL w1_rdata got=%h exp=4321", r1_rdata); end
  endtask

  task automatic test_wait15;
    int ack_at;
    int low;
    for (int t = 0; t < 2; t++) begin
      ack_at = 0; low = 0;
      r15_req = 1'b1; r15_we = (t == 0); r15_addr = 16'h0009; r15_wdata = 16'h0099;
      for (int i = 1; i <= 25; i++) begin
        tick();
        r15_req = 1'b0;
        if ((t == 0 && !r15_wr) || (t == 1 && !r15_rd)) low++;
        if (r15_ack && ack_at == 0) ack_at = i;
      end
      checks++; if (ack_at != 17) begin errors++; $display("FAIL w15_ack_cycle t=%0d got=%0d exp=17", t, ack_at); end
      checks++; if (low != 15) begin errors++; $display("FAIL w15_strobe_len t=%0d got=%0d exp=15", t, low); end
    end
    checks++; if (r15_rdata !== 16'hC0DE) begin errors++; $display("FAIL w15_rdata got=%h exp=c0de", r15_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_hold_inputs();
    test_reset_abort();
    test_wait1();
    test_wait15();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
